// File: rtl/ysyx_23060072_mem_arbiter.sv
// Two-master (IFU/LSU) to one-slave memory arbiter: LSU priority with a bounded
// wait for IFU, one transaction in flight, and flush-aware IFU response dropping.
module ysyx_23060072_mem_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clean_flag_i,
  input  logic        ifu_req_valid_i,
  input  logic [31:0] ifu_addr_i,
  output logic        ifu_req_ready_o,
  output logic        ifu_rsp_valid_o,
  output logic [31:0] ifu_rsp_rdata_o,
  input  logic        lsu_req_valid_i,
  input  logic [31:0] lsu_addr_i,
  input  logic        lsu_wen_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [3:0]  lsu_wmask_i,
  output logic        lsu_req_ready_o,
  output logic        lsu_rsp_valid_o,
  output logic [31:0] lsu_rsp_rdata_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_wen_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wmask_o,
  input  logic        mem_rsp_valid_i,
  input  logic [31:0] mem_rsp_rdata_i,
  output logic [1:0]  dbg_state
);
  // Handshake: a request transfers on a cycle where valid and ready are both high;
  // the requester holds valid and fields until then. Responses are 1-cycle pulses.
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2} state_t;

  state_t        state, state_nxt;
  logic          owner_lsu;
  logic          drop;
  logic [WW-1:0] wait_cnt;
  logic [31:0]   addr_q, wdata_q;
  logic          wen_q;
  logic [3:0]    wmask_q;

  logic force_ifu, grant_ifu, grant_lsu, rsp_fire;

  always_comb begin
    state_nxt = state;
    force_ifu = 1'b0;
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    rsp_fire  = 1'b0;
    case (state)
      IDLE: begin
        force_ifu = (wait_cnt == WW'(MAX_WAIT)) && ifu_req_valid_i;
        grant_lsu = !force_ifu && lsu_req_valid_i;
        grant_ifu = force_ifu ||
                    (!lsu_req_valid_i && ifu_req_valid_i && !clean_flag_i);
        if (grant_ifu || grant_lsu) state_nxt = REQ;
      end
      REQ: if (mem_req_ready_i) state_nxt = RSP;
      RSP: begin
        rsp_fire = mem_rsp_valid_i;
        if (mem_rsp_valid_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner_lsu <= 1'b0;
      drop      <= 1'b0;
      wait_cnt  <= '0;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      wmask_q   <= '0;
    end else begin
      state <= state_nxt;
      if (grant_ifu) begin
        owner_lsu <= 1'b0;
        addr_q    <= ifu_addr_i;
        wen_q     <= 1'b0;
        wdata_q   <= '0;
        wmask_q   <= '0;
        drop      <= clean_flag_i;
        wait_cnt  <= '0;
      end else if (grant_lsu) begin
        owner_lsu <= 1'b1;
        addr_q    <= lsu_addr_i;
        wen_q     <= lsu_wen_i;
        wdata_q   <= lsu_wdata_i;
        wmask_q   <= lsu_wmask_i;
        drop      <= 1'b0;
        if (ifu_req_valid_i && wait_cnt != WW'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
      end
      if (state != IDLE && !owner_lsu && clean_flag_i) drop <= 1'b1;
      // Completion ends the transaction, so it overrides a same-cycle flush.
      if (rsp_fire) drop <= 1'b0;
    end
  end

  assign ifu_req_ready_o = rst_n && grant_ifu;
  assign lsu_req_ready_o = rst_n && grant_lsu;
  assign mem_req_valid_o = rst_n && (state == REQ);
  // A flush arriving with the response itself also suppresses a stale fetch.
  assign ifu_rsp_valid_o = rst_n && rsp_fire && !owner_lsu && !drop && !clean_flag_i;
  assign lsu_rsp_valid_o = rst_n && rsp_fire && owner_lsu;
  assign ifu_rsp_rdata_o = rst_n ? mem_rsp_rdata_i : 32'd0;
  assign lsu_rsp_rdata_o = rst_n ? mem_rsp_rdata_i : 32'd0;
  assign mem_addr_o      = rst_n ? addr_q : 32'd0;
  assign mem_wen_o       = rst_n && wen_q;
  assign mem_wdata_o     = rst_n ? wdata_q : 32'd0;
  assign mem_wmask_o     = rst_n ? wmask_q : 4'd0;
  assign dbg_state       = state;
endmodule

// File: doc/ysyx_23060072_mem_arbiter.md
# ysyx_23060072_mem_arbiter

Two-master, one-slave memory arbiter that shares the core's single data/instruction memory port between the IFU (instruction fetch, read-only) and the LSU (loads/stores). It accepts at most one transaction at a time, latches it, drives it to memory, and routes the response back to the owner. It cooperates with the pipeline controller: an IFU response in flight when the pipeline is flushed is discarded. Normal priority goes to the LSU, with a bounded-wait guarantee for the IFU.

## Interface
- MAX_WAIT, 4, consecutive LSU grants tolerated while IFU is waiting before IFU is forced to win (≥1)
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- clean_flag_i  in  1  pipeline flush from controller
- ifu_req_valid_i  in  1  IFU fetch request
- ifu_addr_i  in  32  fetch address
- ifu_req_ready_o  out  1  IFU request accepted this cycle
- ifu_rsp_valid_o  out  1  fetch data valid (1-cycle pulse)
- ifu_rsp_rdata_o  out  32  fetched instruction
- lsu_req_valid_i  in  1  LSU request
- lsu_addr_i  in  32  access address
- lsu_wen_i  in  1  1 = store, 0 = load
- lsu_wdata_i  in  32  store data
- lsu_wmask_i  in  4  byte-write strobes
- lsu_req_ready_o  out  1  LSU request accepted this cycle
- lsu_rsp_valid_o  out  1  LSU completion (1-cycle pulse, loads and stores)
- lsu_rsp_rdata_o  out  32  load data
- mem_req_valid_o  out  1  request to memory
- mem_req_ready_i  in  1  memory accepts request
- mem_addr_o  out  32 / mem_wen_o  out  1 / mem_wdata_o  out  32 / mem_wmask_o  out  4  latched request fields
- mem_rsp_valid_i  in  1  memory response
- mem_rsp_rdata_i  in  32  memory read data

## Operation
- FSM states: IDLE, REQ, RSP. Registers: owner (IFU/LSU), drop, wait_cnt, latched request.
- IDLE: arbitrate. Winner = IFU if wait_cnt==MAX_WAIT and ifu_req_valid_i; else LSU if lsu_req_valid_i; else IFU if ifu_req_valid_i and !clean_flag_i.
- Winner's *_req_ready_o = 1 (combinational, IDLE only). Request fields are latched (IFU: wen=0, wmask=0, wdata=0) and owner is set. Next state: REQ.
- REQ: mem_req_valid_o = 1 with the latched fields held stable. Leave only on mem_req_ready_i, then go to RSP. The request is never withdrawn.
- RSP: on mem_rsp_valid_i, owner's rsp_valid_o = 1 in the same cycle with rdata = mem_rsp_rdata_i, unless drop is set. Then go to IDLE and clear drop.
- Non-owner rsp_valid_o is always 0. rsp_rdata outputs equal mem_rsp_rdata_i whenever their valid is high and are don't-care otherwise.
- Flush rules:
  - clean_flag_i while owner==IFU in REQ or RSP sets drop. The transaction completes downstream and its response is suppressed.
  - clean_flag_i never affects LSU transactions.
  - clean_flag_i in IDLE blocks an IFU grant that cycle, unless the forced-IFU rule applies. In that case the grant is made and drop is set immediately.
- wait_cnt (width $clog2(MAX_WAIT+1)):
  - +1 on each LSU grant while ifu_req_valid_i = 1, saturating at MAX_WAIT.
  - Cleared on an IFU grant.
  - Unchanged otherwise.

## Timing
- Reset (rst_n low at an edge): state=IDLE, owner=IFU, drop=0, wait_cnt=0, latched fields=0.
- While rst_n=0, all ready/valid outputs are 0, overriding IFU/LSU/mem inputs. Data outputs are 0.
- Reset mid-transaction abandons it with no response.
- Minimum latency: accept at cycle 0 (IDLE); mem_req_valid_o at cycle 1; with mem_req_ready_i=1, RSP at cycle 2.
- With mem_rsp_valid_i in cycle 2, owner's rsp_valid_o is in cycle 2. Next accept is possible in cycle 3, so peak throughput is 1 transaction per 3 cycles.
- mem_rsp_valid_i in REQ or IDLE is ignored (protocol error, no response routed).
- Simultaneous IFU+LSU valid in IDLE: exactly one ready goes high; the other requester must hold its valid and fields.

## Test plan
- Single IFU fetch, addr 0x8000_0000, mem ready immediately, rsp 0x0000_0413 one cycle later -> ifu_req_ready_o cycle 0, mem_req_valid_o cycle 1, ifu_rsp_valid_o with 0x0000_0413 cycle 2, state IDLE cycle 3.
- LSU store addr 0x8000_0100, wdata 0xDEADBEEF, wmask 0xF, mem_req_ready_i delayed 3 cycles -> mem fields stable and valid held 3 cycles; lsu_rsp_valid_o on response; ifu_rsp_valid_o stays 0.
- IFU and LSU both continuously valid, MAX_WAIT=4 -> grant order L,L,L,L,I repeating; wait_cnt 0→4 then cleared.
- IFU fetch granted, clean_flag_i pulsed while in RSP, response 0x1234_5678 -> ifu_rsp_valid_o stays 0, FSM returns to IDLE, next IFU fetch completes normally.
- clean_flag_i in IDLE with only IFU valid -> ifu_req_ready_o=0 that cycle, granted the following cycle.
- rst_n low while in REQ -> mem_req_valid_o=0 next cycle; after release, state IDLE and a fresh LSU load completes normally.
